// File: rtl/dual_rail_result_collector.sv
// Collects results from a duplicated (X/Y) adder with two-rail error codes, selects a
// trustworthy result, requests retries on disagreement and latches a fault when retries run out.
module dual_rail_result_collector #(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       X,
    input  logic             XC,
    input  logic             XE0,
    input  logic             XE1,
    input  logic [2:0]       Y,
    input  logic             YC,
    input  logic             YE0,
    input  logic             YE1,
    input  logic             out_ready,
    input  logic             clr_fault,
    output logic             in_ready,
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic             retry_req,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        RETRY = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       data_d;
    logic [RW-1:0]    rcnt_q;
    logic [RW-1:0]    rcnt_d;
    logic [CNT_W-1:0] ecnt_d;
    logic [CNT_W-1:0] ecnt_inc;
    logic             x_ok;
    logic             y_ok;
    logic [3:0]       x_res;
    logic [3:0]       y_res;

    // A rail is healthy only on code 10; 00 and 11 both flag an error
    assign x_ok     = XE1 & ~XE0;
    assign y_ok     = YE1 & ~YE0;
    assign x_res    = {XC, X};
    assign y_res    = {YC, Y};
    assign ecnt_inc = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);

    // Next-state, held result, retry and error counters
    always_comb begin
        state_d = state_q;
        data_d  = out_data;
        rcnt_d  = rcnt_q;
        ecnt_d  = err_cnt;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (x_ok && y_ok && (x_res == y_res)) begin
                        data_d  = x_res;
                        rcnt_d  = '0;
                        state_d = HOLD;
                    end else if (x_ok ^ y_ok) begin
                        data_d  = x_ok ? x_res : y_res;
                        rcnt_d  = '0;
                        ecnt_d  = ecnt_inc;
                        state_d = HOLD;
                    end else begin
                        ecnt_d = ecnt_inc;
                        if (32'(rcnt_q) < MAX_RETRY) begin
                            rcnt_d  = rcnt_q + RW'(1);
                            state_d = RETRY;
                        end else begin
                            state_d = FAULT;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            RETRY: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (clr_fault) begin
                    rcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; status outputs are registered decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_data  <= '0;
            rcnt_q    <= '0;
            err_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            retry_req <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_data  <= data_d;
            rcnt_q    <= rcnt_d;
            err_cnt   <= ecnt_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == HOLD);
            retry_req <= (state_d == RETRY);
            fault     <= (state_d == FAULT);
        end
    end

endmodule

// File: tb/tb_dual_rail_result_collector.sv
// Self-checking bench for dual_rail_result_collector: directed scenarios plus random traffic
// compared against a behavioural model of the collector.
module tb_dual_rail_result_collector;

    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned CNT_W     = 4;
    localparam int          CAP       = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [2:0]       X;
    logic             XC;
    logic             XE0;
    logic             XE1;
    logic [2:0]       Y;
    logic             YC;
    logic             YE0;
    logic             YE1;
    logic             out_ready;
    logic             clr_fault;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       out_data;
    logic             retry_req;
    logic             fault;
    logic [CNT_W-1:0] err_cnt;

    int n_checks;
    int n_pass;

    // Model: what the collector is currently doing, in plain terms
    bit m_holding;
    bit m_retrying;
    bit m_faulted;
    int m_data;
    int m_retries;
    int m_errors;

    dual_rail_result_collector #(.MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .X(X), .XC(XC), .XE0(XE0), .XE1(XE1),
        .Y(Y), .YC(YC), .YE0(YE0), .YE1(YE1),
        .out_ready(out_ready), .clr_fault(clr_fault),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .retry_req(retry_req), .fault(fault), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_holding = 0; m_retrying = 0; m_faulted = 0;
        m_data = 0; m_retries = 0; m_errors = 0;
    endtask

    // One clock of the collector's rules, applied to the inputs present before the edge
    task automatic model_step();
        bit xok, yok;
        int xr, yr;
        xok = XE1 && !XE0;
        yok = YE1 && !YE0;
        xr  = {XC, X};
        yr  = {YC, Y};
        if (m_holding) begin
            if (out_ready) m_holding = 0;
        end else if (m_retrying) begin
            m_retrying = 0;
        end else if (m_faulted) begin
            if (clr_fault) begin m_faulted = 0; m_retries = 0; end
        end else if (in_valid) begin
            if (xok && yok && xr == yr) begin
                m_data = xr; m_holding = 1; m_retries = 0;
            end else if (xok != yok) begin
                m_data = xok ? xr : yr; m_holding = 1; m_retries = 0;
                m_errors++;
            end else begin
                m_errors++;
                if (m_retries < MAX_RETRY) begin m_retries++; m_retrying = 1; end
                else m_faulted = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int e;
        e = (m_errors > CAP) ? CAP : m_errors;
        check({tag, ".in_ready"},  32'(in_ready),  32'(!(m_holding || m_retrying || m_faulted)));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_holding));
        check({tag, ".out_data"},  32'(out_data),  32'(m_data));
        check({tag, ".retry_req"}, 32'(retry_req), 32'(m_retrying));
        check({tag, ".fault"},     32'(fault),     32'(m_faulted));
        check({tag, ".err_cnt"},   32'(err_cnt),   32'(e));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input logic [3:0] xr, input logic [1:0] xe,
                         input logic [3:0] yr, input logic [1:0] ye,
                         input bit ordy, input bit clr);
        in_valid = v;
        {XC, X} = xr; {XE1, XE0} = xe;
        {YC, Y} = yr; {YE1, YE0} = ye;
        out_ready = ordy; clr_fault = clr;
    endtask

    task automatic idle_inputs(input bit ordy);
        drive(1'b0, 4'h0, 2'b10, 4'h0, 2'b10, ordy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs(1'b1);
        rst_n = 1'b1;
        #3;
        do_reset();

        // Clean matching result on first edge after reset, 1-cycle latency
        drive(1'b1, 4'b0101, 2'b10, 4'b0101, 2'b10, 1'b1, 1'b0);
        cycle("clean_accept");
        check("clean_data", 32'(out_data), 32'h5);
        idle_inputs(1'b1);
        cycle("clean_release");

        // X rail bad, Y used
        drive(1'b1, 4'b1011, 2'b11, 4'b0100, 2'b10, 1'b1, 1'b0);
        cycle("x_bad");
        check("x_bad_data", 32'(out_data), 32'h4);
        idle_inputs(1'b1);
        cycle("x_bad_release");

        // Disagreement -> retry pulse, then clean resubmit
        drive(1'b1, 4'b0010, 2'b10, 4'b0011, 2'b10, 1'b1, 1'b0);
        cycle("mismatch");
        idle_inputs(1'b1);
        cycle("mismatch_end");
        drive(1'b1, 4'b0010, 2'b10, 4'b0010, 2'b10, 1'b1, 1'b0);
        cycle("resubmit");
        idle_inputs(1'b1);
        cycle("resubmit_release");

        // Three double errors -> two retries then fault; clr_fault recovers
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h1, 2'b00, 4'h2, 2'b11, 1'b1, 1'b0);
            cycle("dbl_err");
            idle_inputs(1'b1);
            cycle("dbl_err_next");
        end
        check("fault_latched", 32'(fault), 32'h1);
        idle_inputs(1'b1);
        cycle("fault_stays");
        drive(1'b0, 4'h0, 2'b10, 4'h0, 2'b10, 1'b1, 1'b1);
        cycle("clr_fault");
        check("err_after_clr", 32'(err_cnt), 32'(m_errors));

        // Back-pressure: inputs wiggle while held
        drive(1'b1, 4'b1110, 2'b10, 4'b1110, 2'b10, 1'b0, 1'b0);
        cycle("bp_accept");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 1'b0, 1'($urandom));
            cycle("bp_hold");
        end
        check("bp_data", 32'(out_data), 32'hE);
        idle_inputs(1'b1);
        cycle("bp_release");

        // Saturation with single-rail errors
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'($urandom), 2'b10, 4'($urandom), 2'b01, 1'b1, 1'b0);
            cycle("sat_accept");
            idle_inputs(1'b1);
            cycle("sat_release");
        end
        check("sat_cnt", 32'(err_cnt), 32'(CAP));

        // Reset mid-HOLD
        drive(1'b1, 4'h7, 2'b10, 4'h7, 2'b10, 1'b0, 1'b0);
        cycle("pre_reset_hold");
        do_reset();

        // Random traffic, with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic [1:0] xe, ye;
            logic [3:0] xr, yr;
            xr = 4'($urandom);
            yr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : xr;
            xe = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            ye = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            drive(1'($urandom), xr, xe, yr, ye, 1'($urandom), ($urandom_range(0, 3) == 0));
            cycle("rand");
            if (i % 150 == 149) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dual_rail_result_collector.md
DUAL_RAIL_RESULT_COLLECTOR -- requirements
Module: dual_rail_result_collector

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2, meaning consecutive retries allowed before fault.
REQ-002 SHALL have parameter CNT_W, default 4, meaning error counter width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream adder result present.
REQ-007 X  in  3  X-channel sum bits {X2,X1,X0}; XC  in  1  X-channel carry.
REQ-008 XE0, XE1  in  1 each  X-channel two-rail error code.
REQ-009 Y  in  3  Y-channel sum; YC  in  1  Y carry; YE0, YE1  in  1 each  Y error code.
REQ-010 out_ready  in  1  downstream accepts out_data.
REQ-011 clr_fault  in  1  operator fault clear.
REQ-012 in_ready  out  1  collector can accept a result.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_data  out  4  selected result {carry, sum[2:0]}.
REQ-015 retry_req  out  1  one-cycle pulse: upstream must resubmit the operation.
REQ-016 fault  out  1  unrecoverable fault latched.
REQ-017 err_cnt  out  CNT_W  saturating count of detected errors.

Function
REQ-018 Channel OK SHALL mean E1=1 and E0=0; codes 00 and 11 are errors.
REQ-019 States SHALL be IDLE, HOLD, RETRY, FAULT; in_ready=1 only in IDLE.
REQ-020 Accept SHALL occur on the rising edge where in_valid=1 and in_ready=1; inputs outside accept are ignored.
REQ-021 Accept, both OK and {XC,X}=={YC,Y}: out_data<={XC,X}; -> HOLD; retry counter cleared; err_cnt unchanged.
REQ-022 Accept, exactly one channel OK: out_data<=OK channel's {C,sum}; -> HOLD; retry counter cleared; err_cnt+1.
REQ-023 Accept, both OK but results differ, or neither OK: err_cnt+1; if retry counter < MAX_RETRY, retry counter+1 and -> RETRY, else -> FAULT.
REQ-024 out_valid SHALL be 1 exactly in HOLD; latency accept->out_valid = 1 cycle.
REQ-025 out_data SHALL hold stable throughout HOLD; HOLD -> IDLE on the edge where out_ready=1.
REQ-026 RETRY SHALL last exactly one cycle with retry_req=1, then -> IDLE; retry_req=0 in all other states.
REQ-027 FAULT: fault=1, in_ready=0, out_valid=0; stays until clr_fault=1 sampled, then -> IDLE with retry counter cleared.
REQ-028 clr_fault outside FAULT SHALL have no effect; err_cnt is never cleared by clr_fault.
REQ-029 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 Retry counter SHALL be ceil(log2(MAX_RETRY+1)) bits minimum, internal only.
REQ-031 MAX_RETRY=0 SHALL send any double-error accept directly to FAULT.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, out_data=0, retry_req=0, fault=0, err_cnt=0, retry counter=0.
REQ-033 Reset assertion mid-HOLD, RETRY or FAULT SHALL discard the held result/fault with no further output.
REQ-034 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 X=101,XC=0,XE=01,Y=101,YC=0,YE=01, out_ready=1 -> next cycle out_valid=1, out_data=0101; following cycle IDLE, err_cnt=0.
REQ-036 X=011,XC=1,XE=11 (bad), Y=100,YC=0,YE=01 -> out_data=0100, err_cnt=1, retry_req stays 0.
REQ-037 Both OK, X=010 vs Y=011 -> retry_req pulses 1 cycle, in_ready=0 that cycle; resubmit clean 010/010 -> out_data=0010, err_cnt=1.
REQ-038 Three consecutive double-error accepts (MAX_RETRY=2) -> two retry_req pulses, then fault=1, in_ready=0; clr_fault=1 -> IDLE, fault=0, err_cnt=3.
REQ-039 Hold out_ready=0 for 5 cycles in HOLD while changing inputs -> out_data unchanged, in_ready=0; then out_ready=1 -> IDLE.
REQ-040 Drive 20 single-channel-error accepts with CNT_W=4 -> err_cnt saturates at 15; assert rst_n=0 mid-HOLD -> all outputs return to reset values immediately.
